// File: rtl/fifo_credit_tx_pkg.sv
// Shared defaults for the credit-based link transmitter.
//   DEF_WIDTH   : link word width, matches the receiving fifo
//   DEF_CREDITS : receiving fifo depth, i.e. initial credit count
package fifo_credit_tx_pkg;

  localparam int unsigned DEF_WIDTH   = 19;
  localparam int unsigned DEF_CREDITS = 4;

endpackage : fifo_credit_tx_pkg

// File: rtl/fifo_credit_tx_credit_counter.sv
// Saturating up/down credit counter with a sticky overflow flag.
// Starts at MAX after reset. A decrement and an increment in the same
// cycle cancel. An increment while already at MAX holds the count at MAX
// and sets overflow, which stays set until reset.
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   dec      : consume one credit (ignored when count is zero)
//   inc      : one credit returned
//   count    : current credit count
//   nonzero  : count != 0
//   overflow : sticky, credit returned while count was already MAX
module credit_counter #(
  parameter int unsigned MAX   = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dec,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             nonzero,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             overflow_q;
  logic             overflow_d;
  logic             dec_ok;

  assign dec_ok = dec && (count_q != '0);

  always_comb begin
    count_d    = count_q;
    overflow_d = overflow_q;
    if (dec_ok && !inc) begin
      count_d = count_q - 1'b1;
    end else if (inc && !dec_ok) begin
      if (count_q == MAX_CNT) begin
        overflow_d = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= MAX_CNT;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign count    = count_q;
  assign nonzero  = (count_q != '0);
  assign overflow = overflow_q;

endmodule : credit_counter

// File: rtl/fifo_credit_tx.sv
// Transmit end of a credit-based link into a remote fifo. Words accepted on
// a valid/ready stream are forwarded one cycle later on a valid-only link;
// the number of words in flight never exceeds the receiver's free slots.
//   clk           : clock, rising edge
//   rst_n         : asynchronous active-low reset
//   in_valid      : upstream word valid
//   in_data       : upstream word
//   in_ready      : upstream may transfer this cycle (registered count only)
//   tx_valid      : link word valid, no back-pressure
//   tx_data       : link word, held when tx_valid is low
//   credit_return : one-cycle pulse, receiver freed one slot
//   credit_count  : credits currently available
//   idle          : all credits home and nothing on the link
//   credit_err    : sticky, credit returned while already at CREDITS
module fifo_credit_tx
  import fifo_credit_tx_pkg::*;
#(
  parameter  int unsigned WIDTH   = DEF_WIDTH,
  parameter  int unsigned CREDITS = DEF_CREDITS,
  localparam int unsigned CNT_W   = $clog2(CREDITS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             tx_valid,
  output logic [WIDTH-1:0] tx_data,
  input  logic             credit_return,
  output logic [CNT_W-1:0] credit_count,
  output logic             idle,
  output logic             credit_err
);

  logic             send;
  logic             has_credit;
  logic             tx_valid_q;
  logic [WIDTH-1:0] tx_data_q;

  credit_counter #(
    .MAX   (CREDITS),
    .CNT_W (CNT_W)
  ) u_credit_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .dec      (send),
    .inc      (credit_return),
    .count    (credit_count),
    .nonzero  (has_credit),
    .overflow (credit_err)
  );

  // Ready depends only on the registered count, so a return lands one
  // cycle later and there is no comb path from the link back upstream.
  assign in_ready = has_credit;
  assign send     = in_valid && has_credit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      tx_valid_q <= send;
      // Data only loads on a send so the link stays quiet between words.
      if (send) begin
        tx_data_q <= in_data;
      end
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign idle     = (credit_count == CNT_W'(CREDITS)) && !tx_valid_q;

endmodule : fifo_credit_tx
